// File: rtl/tt_um_ha_serial_seq.sv
// Bit-serial unsigned adder: A+B computed LSB first through one shared full
// adder built from two half adders, controlled by an IDLE/RUN/DONE sequencer.
module tt_um_ha_serial_seq #(
  parameter int N_BITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DONE  = 2'b10,
    SPARE = 2'b11
  } state_t;

  state_t              state_q;
  logic [N_BITS-1:0]   a_q;
  logic [N_BITS-1:0]   b_q;
  logic [N_BITS-1:0]   sum_q;
  logic                carry_q;
  logic [CW-1:0]       cnt_q;
  logic [N_BITS:0]     result_q;
  logic                busy_q;
  logic                done_q;
  logic                ign_q;

  logic start;
  logic clear;
  logic [N_BITS-1:0] op_a;
  logic [N_BITS-1:0] op_b;

  assign start = uio_in[0];
  assign clear = uio_in[1];
  assign op_a  = ui_in[N_BITS-1:0];
  assign op_b  = ui_in[2*N_BITS-1:N_BITS];

  logic unused_uio;
  assign unused_uio = &{1'b0, uio_in[7:2]};

  // Shared full adder: two half adders, carries merged by an OR.
  logic ha1_s, ha1_c, ha2_s, ha2_c;
  logic fa_sum, fa_cout;

  always_comb begin
    ha1_s   = a_q[0] ^ b_q[0];
    ha1_c   = a_q[0] & b_q[0];
    ha2_s   = ha1_s ^ carry_q;
    ha2_c   = ha1_s & carry_q;
    fa_sum  = ha2_s;
    fa_cout = ha1_c | ha2_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ign_q    <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        state_q  <= IDLE;
        a_q      <= '0;
        b_q      <= '0;
        sum_q    <= '0;
        carry_q  <= 1'b0;
        cnt_q    <= '0;
        result_q <= '0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        ign_q    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (start) begin
              a_q     <= op_a;
              b_q     <= op_b;
              sum_q   <= '0;
              carry_q <= 1'b0;
              cnt_q   <= '0;
              ign_q   <= 1'b0;
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          RUN: begin
            if (start) ign_q <= 1'b1;
            sum_q   <= {fa_sum, sum_q[N_BITS-1:1]};
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= fa_cout;
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(N_BITS - 1)) begin
              // Final bit bypasses the shift register so the result lands this edge.
              result_q <= {fa_cout, fa_sum, sum_q[N_BITS-1:1]};
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign uo_out  = {ign_q, done_q, busy_q, result_q};
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_ha_serial_seq.sv
// Directed bench for the bit-serial adder: table of operand pairs plus
// hand-written sequences for start collision, clear, stall and reset.
module tb_tt_um_ha_serial_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  logic [4:0] prev_res;

  tt_um_ha_serial_seq #(.N_BITS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start, then four RUN edges; result must hold its old value until done.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [4:0] exp);
    ui_in  = {b, a};
    uio_in = 8'h01;
    tick();
    uio_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      chk("run_busy", {7'd0, uo_out[5]}, 8'd1);
      chk("run_done", {7'd0, uo_out[6]}, 8'd0);
      chk("run_hold", {3'd0, uo_out[4:0]}, {3'd0, prev_res});
      tick();
    end
    chk("op_result", {3'd0, uo_out[4:0]}, {3'd0, exp});
    chk("op_flags", {6'd0, uo_out[6:5]}, 8'b10);
    prev_res = exp;
  endtask

  initial begin
    vecs[0] = '{4'd9,  4'd7,  5'd16};
    vecs[1] = '{4'd15, 4'd15, 5'd30};
    vecs[2] = '{4'd0,  4'd0,  5'd0};
    vecs[3] = '{4'd3,  4'd5,  5'd8};
    vecs[4] = '{4'd10, 4'd5,  5'd15};
    vecs[5] = '{4'd1,  4'd1,  5'd2};
    vecs[6] = '{4'd15, 4'd1,  5'd16};
    vecs[7] = '{4'd8,  4'd8,  5'd16};

    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    prev_res = 5'd0;
    #1;
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_uo", uo_out, 8'h00);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sum);

    // Start during RUN is ignored but flagged; flag clears on next accepted start.
    ui_in = {4'd5, 4'd3}; uio_in = 8'h01; tick();
    uio_in = 8'h00; tick();
    uio_in = 8'h01; tick();
    chk("ign_set", {7'd0, uo_out[7]}, 8'd1);
    uio_in = 8'h00; tick(); tick();
    chk("ign_result", uo_out, 8'hC8);
    tick();
    chk("ign_sticky", uo_out, 8'hC8);
    ui_in = {4'd1, 4'd2}; uio_in = 8'h01; tick();
    chk("ign_cleared", {7'd0, uo_out[7]}, 8'd0);
    uio_in = 8'h00;
    tick(); tick(); tick(); tick();
    chk("after_ign", uo_out, 8'h43);
    prev_res = 5'd3;

    // Clear mid-RUN aborts to IDLE with everything zeroed.
    ui_in = {4'd6, 4'd6}; uio_in = 8'h01; tick();
    uio_in = 8'h00; tick();
    uio_in = 8'h02; tick();
    chk("clear_now", uo_out, 8'h00);
    uio_in = 8'h00;
    tick(); tick(); tick(); tick();
    chk("clear_no_done", uo_out, 8'h00);
    prev_res = 5'd0;

    // ena low for three cycles mid-RUN; operands changed after accept.
    ui_in = {4'd5, 4'd10}; uio_in = 8'h01; tick();
    uio_in = 8'h00; ui_in = 8'hFF; tick();
    ena = 1'b0;
    uio_in = 8'h03;
    tick(); tick(); tick();
    chk("stall_hold", uo_out, 8'h20);
    uio_in = 8'h00; ena = 1'b1;
    tick(); tick();
    chk("stall_still_busy", uo_out, 8'h20);
    tick();
    chk("stall_result", uo_out, 8'h4F);
    prev_res = 5'd15;

    // ena low ignores start and clear in DONE.
    ena = 1'b0; uio_in = 8'h01; tick();
    uio_in = 8'h02; tick();
    chk("ena_low_done", uo_out, 8'h4F);
    ena = 1'b1; uio_in = 8'h00;

    // Asynchronous reset mid-RUN, checked before the next edge.
    ui_in = {4'd7, 4'd9}; uio_in = 8'h01; tick();
    uio_in = 8'h00; tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", uo_out, 8'h00);
    #1 rst_n = 1'b1;
    tick();
    chk("post_reset", uo_out, 8'h00);
    prev_res = 5'd0;
    run_op(4'd9, 4'd7, 5'd16);

    // Start held: back-to-back ops, operands resampled at each accept.
    ui_in = {4'd3, 4'd2}; uio_in = 8'h01; tick();
    ui_in = {4'd4, 4'd4};
    tick(); tick(); tick(); tick();
    chk("b2b_first", uo_out[6:0], 7'h45);
    tick();
    chk("b2b_restart", {1'b0, uo_out[6:0]}, 8'h25);
    tick(); tick(); tick();
    uio_in = 8'h00;
    tick();
    chk("b2b_second", {1'b0, uo_out[6:0]}, 8'h48);
    tick();
    chk("b2b_done_hold", {1'b0, uo_out[6:0]}, 8'h48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
